// File: rtl/store_buffer_pkg.sv
// Shared pipeline constants for the store buffer: default depth and entry-field widths.
package store_buffer_pkg;

  localparam int unsigned SbDepth = 4;
  localparam int unsigned SbAddrW = 32;
  localparam int unsigned SbDataW = 32;

  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match forwarding search: priority selector over the buffer entries,
// scanned from the write pointer backwards.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepth,
  parameter int unsigned AW    = SbAddrW,
  localparam int unsigned PW   = sb_ptr_w(DEPTH)
) (
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0][AW-1:0]      addr,
  input  logic [DEPTH-1:0][SbDataW-1:0] data,
  input  logic [PW-1:0]                 wptr,
  input  logic [AW-1:0]                 ld_addr,
  output logic                          hit,
  output logic [SbDataW-1:0]            hit_data
);

  logic [PW-1:0] idx;

  // Walk oldest (wptr - DEPTH) to youngest (wptr - 1); a later match overrides an earlier one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = wptr - PW'(i);
      if (valid[idx] && (addr[idx] == ld_addr)) begin
        hit      = 1'b1;
        hit_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores drained to memory when no load
// occupies the port, with youngest-match store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SbDepth,
  parameter int unsigned AW    = SbAddrW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_valid,
  input  logic [AW-1:0]      st_addr,
  input  logic [SbDataW-1:0] st_data,
  output logic               st_ready,
  input  logic               ld_valid,
  input  logic [AW-1:0]      ld_addr,
  output logic [SbDataW-1:0] ld_data,
  output logic               mem_we,
  output logic [AW-1:0]      mem_a,
  output logic [SbDataW-1:0] mem_wd,
  input  logic [SbDataW-1:0] mem_rd,
  output logic               empty
);

  localparam int unsigned PW   = sb_ptr_w(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [DEPTH-1:0][AW-1:0]      addr_q;
  logic [DEPTH-1:0][SbDataW-1:0] data_q;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [PW-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic                          drain, push, fwd_hit;
  logic [SbDataW-1:0]            fwd_data;

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd (
    .valid    (valid_q),
    .addr     (addr_q),
    .data     (data_q),
    .wptr     (wptr_q),
    .ld_addr  (ld_addr),
    .hit      (fwd_hit),
    .hit_data (fwd_data)
  );

  // Outputs are qualified by rst so the reset-time values hold even with a load presented.
  always_comb begin
    drain    = rst && (count_q != '0) && !ld_valid;
    st_ready = rst && ((count_q != Full) || drain);
    push     = st_valid && st_ready;
    empty    = (count_q == '0);
    mem_we   = drain;
    mem_a    = '0;
    mem_wd   = '0;
    ld_data  = '0;
    if (rst) begin
      ld_data = fwd_hit ? fwd_data : mem_rd;
      if (ld_valid) begin
        mem_a = ld_addr;
      end else if (drain) begin
        mem_a  = addr_q[rptr_q];
        mem_wd = data_q[rptr_q];
      end
    end
  end

  always_comb begin
    wptr_d  = push  ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = drain ? rptr_q + PW'(1) : rptr_q;
    valid_d = valid_q;
    // Clear before set: when full, push and drain can hit the same slot.
    if (drain) valid_d[rptr_q] = 1'b0;
    if (push)  valid_d[wptr_q] = 1'b1;
    unique case ({push, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= st_addr;
      data_q[wptr_q] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-level model predicts each cycle's
// responses; a negedge monitor pops and compares them against the DUT.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  typedef struct {
    logic        rdy;
    logic        we;
    logic [31:0] a;
    logic        lv;
    logic [31:0] ld;
    logic        emp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, ld_valid, st_ready, mem_we, empty;
  logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_a, mem_wd, mem_rd;

  st_t  pend[$];     // stores accepted but not yet written to memory
  st_t  exp_wr[$];   // expected memory writes, in push order
  cyc_t exp_cyc[$];  // expected per-cycle responses

  int n_chk  = 0;
  int n_pass = 0;

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Drive one cycle of stimulus and record the model's prediction for it.
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic [31:0] rd,
                       output logic acc);
    int   n;
    logic drn, rdy;
    cyc_t c;
    @(posedge clk);
    #1;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; mem_rd = rd;
    n     = pend.size();
    drn   = (n > 0) && !lv;
    rdy   = (n < int'(DEPTH)) || drn;
    c.ld  = rd;
    for (int i = 0; i < n; i++) if (pend[i].a == la) c.ld = pend[i].d;
    c.a   = lv ? la : (drn ? pend[0].a : 32'd0);
    c.we  = drn;
    c.rdy = rdy;
    c.lv  = lv;
    c.emp = (n == 0);
    exp_cyc.push_back(c);
    if (drn) void'(pend.pop_front());
    acc = sv && rdy;
    if (acc) begin
      pend.push_back('{a: sa, d: sd});
      exp_wr.push_back('{a: sa, d: sd});
    end
  endtask

  task automatic idle(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, $urandom, acc);
  endtask

  // Monitor: compare per-cycle responses, and every memory write against push order.
  always @(negedge clk) begin
    cyc_t c;
    st_t  w;
    if (rst_n && exp_cyc.size() > 0) begin
      c = exp_cyc.pop_front();
      chk("st_ready", {31'd0, st_ready}, {31'd0, c.rdy});
      chk("mem_we", {31'd0, mem_we}, {31'd0, c.we});
      chk("mem_a", mem_a, c.a);
      chk("empty", {31'd0, empty}, {31'd0, c.emp});
      if (c.lv) chk("ld_data", ld_data, c.ld);
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = exp_wr.pop_front();
          chk("drain_addr", mem_a, w.a);
          chk("drain_data", mem_wd, w.d);
        end
      end
    end
  end

  initial begin
    logic acc;
    int   guard;
    rst_n = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b1; ld_addr = 32'h44; mem_rd = 32'hdead_beef;
    #2;
    chk("rst_st_ready", {31'd0, st_ready}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single store drains the next cycle, then buffer is empty.
    drive(1'b1, 32'd28, 32'h55, 1'b0, 32'd0, 32'h0, acc);
    idle(2);

    // Two stores to one address under a held load: youngest forwarded, drain blocked.
    drive(1'b1, 32'd40, 32'h1, 1'b1, 32'd40, 32'h77, acc);
    drive(1'b1, 32'd40, 32'h2, 1'b1, 32'd40, 32'h77, acc);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd40, 32'h77, acc);
    idle(3);

    // Non-matching load returns memory data.
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd28, 32'h20, acc);

    // DEPTH+1 stores with load held: last one stalls until the first drain.
    for (int k = 0; k <= int'(DEPTH); k++)
      drive(1'b1, 32'h100 + 32'(k * 4), 32'ha0 + 32'(k), 1'b1, 32'h900, $urandom, acc);
    drive(1'b1, 32'h100 + 32'(DEPTH * 4), 32'ha0 + 32'(DEPTH), 1'b0, 32'd0, $urandom, acc);
    idle(DEPTH + 2);

    // Reset with three stores pending: all discarded, no write afterwards.
    for (int k = 0; k < 3; k++)
      drive(1'b1, 32'h200 + 32'(k * 4), $urandom, 1'b1, 32'h300, $urandom, acc);
    @(negedge clk);
    #1;
    st_valid = 1'b1; ld_valid = 1'b1; ld_addr = 32'h204;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_st_ready", {31'd0, st_ready}, 32'd0);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_mem_a", mem_a, 32'd0);
    chk("mid_rst_mem_wd", mem_wd, 32'd0);
    chk("mid_rst_ld_data", ld_data, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    pend.delete();
    exp_wr.delete();
    st_valid = 1'b0; ld_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Pointer wrap: ten back-to-back stores with concurrent drains.
    for (int k = 0; k < 10; k++)
      drive(1'b1, 32'h400 + 32'(k * 4), 32'hc000 + 32'(k), 1'b0, 32'd0, $urandom, acc);
    idle(3);

    // Randomized traffic over a small address set so forwarding hits often.
    for (int k = 0; k < 400; k++)
      drive(1'($urandom % 2), 32'($urandom % 6) * 4, $urandom, ($urandom % 3) == 0,
            32'($urandom % 6) * 4, $urandom, acc);

    guard = 0;
    while (pend.size() > 0 && guard < 40) begin
      idle(1);
      guard++;
    end
    idle(1);
    @(negedge clk);
    #1;
    chk("writes_outstanding", 32'(exp_wr.size()), 32'd0);
    chk("buffer_empty", {31'd0, empty}, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
